// File: rtl/hue_fade_sequencer.sv
// Six-segment RGB colour-wheel fade: one channel ramps per segment while the
// other two hold at 0 or full scale; each output drives one pwm duty input.
`timescale 1ns / 1ps

module hue_fade_sequencer #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned STEP_CYCLES  = 2000,
    parameter int unsigned INC          = 1,
    localparam int unsigned W           = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         restart,
    output logic [W-1:0] r_value,
    output logic [W-1:0] g_value,
    output logic [W-1:0] b_value,
    output logic [2:0]   segment,
    output logic         wheel_done
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] StepLast = CW'(STEP_CYCLES - 1);
    localparam logic [W-1:0]  MaxVal   = W'(PWM_INTERVAL - 1);
    localparam logic [W:0]    MaxExt   = (W + 1)'(PWM_INTERVAL - 1);
    localparam logic [W:0]    IncExt   = (W + 1)'(INC);

    typedef enum logic [2:0] {
        SegGUp = 3'd0,
        SegRDn = 3'd1,
        SegBUp = 3'd2,
        SegGDn = 3'd3,
        SegRUp = 3'd4,
        SegBDn = 3'd5
    } seg_e;

    seg_e          seg_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  r_q, g_q, b_q;
    logic          wheel_done_q;

    logic          ramp_up;
    logic [W-1:0]  ramp_cur;
    logic [W:0]    ramp_sum;
    logic [W:0]    ramp_nxt_ext;
    logic          ramp_done;

    // Extra headroom bit so the up-ramp can clamp instead of wrapping.
    always_comb begin
        ramp_up      = 1'b0;
        ramp_cur     = '0;
        ramp_sum     = '0;
        ramp_nxt_ext = '0;
        unique case (seg_q)
            SegGUp: begin ramp_cur = g_q; ramp_up = 1'b1; end
            SegRDn: ramp_cur = r_q;
            SegBUp: begin ramp_cur = b_q; ramp_up = 1'b1; end
            SegGDn: ramp_cur = g_q;
            SegRUp: begin ramp_cur = r_q; ramp_up = 1'b1; end
            SegBDn: ramp_cur = b_q;
            default: ;
        endcase
        if (ramp_up) begin
            ramp_sum     = {1'b0, ramp_cur} + IncExt;
            ramp_nxt_ext = (ramp_sum >= MaxExt) ? MaxExt : ramp_sum;
        end else begin
            ramp_nxt_ext = ({1'b0, ramp_cur} <= IncExt) ? '0 : ({1'b0, ramp_cur} - IncExt);
        end
        ramp_done = ramp_up ? (ramp_nxt_ext == MaxExt) : (ramp_nxt_ext == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SegGUp;
            cnt_q        <= '0;
            r_q          <= MaxVal;
            g_q          <= '0;
            b_q          <= '0;
            wheel_done_q <= 1'b0;
        end else begin
            wheel_done_q <= 1'b0;
            if (restart) begin
                seg_q <= SegGUp;
                cnt_q <= '0;
                r_q   <= MaxVal;
                g_q   <= '0;
                b_q   <= '0;
            end else if (enable) begin
                if (cnt_q == StepLast) begin
                    cnt_q <= '0;
                    unique case (seg_q)
                        SegGUp, SegGDn: g_q <= ramp_nxt_ext[W-1:0];
                        SegRDn, SegRUp: r_q <= ramp_nxt_ext[W-1:0];
                        SegBUp, SegBDn: b_q <= ramp_nxt_ext[W-1:0];
                        default: ;
                    endcase
                    // Constant channels already sit where the next segment needs them.
                    if (ramp_done) begin
                        unique case (seg_q)
                            SegGUp: seg_q <= SegRDn;
                            SegRDn: seg_q <= SegBUp;
                            SegBUp: seg_q <= SegGDn;
                            SegGDn: seg_q <= SegRUp;
                            SegRUp: seg_q <= SegBDn;
                            SegBDn: begin
                                seg_q        <= SegGUp;
                                wheel_done_q <= 1'b1;
                            end
                            default: seg_q <= SegGUp;
                        endcase
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign r_value    = r_q;
    assign g_value    = g_q;
    assign b_value    = b_q;
    assign segment    = seg_q;
    assign wheel_done = wheel_done_q;

endmodule
